// File: rtl/dvp_pkg.sv
// dvp_pkg: shared DVP types, underrun fill value and colour-bar constants.
// Bar colours are also used by the capture-side checker.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    ACTIVE,
    HBLANK
  } dvp_state_e;

  localparam logic [15:0] UNDERRUN_PIXEL = 16'h0000;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(
    input logic [2:0] idx
  );
    logic [15:0] c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// dvp_tx_timing: pclk divider, tick strobes and frame/line FSM.
// State and counters advance only on ticks (pclk falling).
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int H_BLANK      = 16,
  parameter int VBLANK_LINES = 2,
  parameter int PCLK_DIV     = 2,
  localparam int LINE = 2 * H_ACTIVE + H_BLANK,
  localparam int BW   = $clog2(LINE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  output logic          pclk_o,
  output logic          tick_o,
  output logic          pre_tick_o,
  output dvp_state_e    state_o,
  output dvp_state_e    state_d_o,
  output logic [BW-1:0] byte_d_o,
  output logic          frame_end_o
);

  localparam int HALF = PCLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PRE  = (HALF > 1) ? HALF - 2 : 0;
  localparam int LT   = V_ACTIVE + VBLANK_LINES;
  localparam int LW   = (LT > 1) ? $clog2(LT) : 1;

  logic [DW-1:0] div_q;
  logic          pclk_q;
  dvp_state_e    state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic          frame_end;

  assign pclk_o      = pclk_q;
  assign tick_o      = pclk_q && (div_q == DW'(HALF - 1));
  assign pre_tick_o  = (HALF == 1) ? !pclk_q
                     : (pclk_q && (div_q == DW'(PRE)));
  assign state_o     = state_q;
  assign state_d_o   = state_d;
  assign byte_d_o    = byte_d;
  assign frame_end_o = frame_end;

  // pclk divider, free-running whenever out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else if (div_q == DW'(HALF - 1)) begin
      div_q  <= '0;
      pclk_q <= !pclk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // state and counters, committed on ticks only
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      line_q  <= '0;
    end else if (tick_o) begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

  // next state; counters reload on every state change
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q + 1'b1;
    line_d    = line_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        byte_d = '0;
        line_d = '0;
        if (enable_i) state_d = VBLANK;
      end
      VBLANK: begin
        if (!enable_i) begin
          state_d = IDLE;
          byte_d  = '0;
          line_d  = '0;
        end else if (byte_q == BW'(LINE - 1)) begin
          byte_d = '0;
          if (line_q == LW'(VBLANK_LINES - 1)) begin
            state_d = ACTIVE;
            line_d  = '0;
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (byte_q == BW'(2 * H_ACTIVE - 1)) begin
          state_d = HBLANK;
          byte_d  = '0;
        end
      end
      HBLANK: begin
        if (byte_q == BW'(H_BLANK - 1)) begin
          byte_d = '0;
          if (line_q == LW'(V_ACTIVE - 1)) begin
            frame_end = 1'b1;
            line_d    = '0;
            state_d   = enable_i ? VBLANK : IDLE;
          end else begin
            state_d = ACTIVE;
            line_d  = line_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        byte_d  = '0;
        line_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dvp_pixel_tx.sv
// dvp_pixel_tx: 16-bit pixel stream to DVP pclk/vsync/href/data.
// Optional colour bars via DVP_TX_TEST_PATTERN_EN.
module dvp_pixel_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int H_BLANK      = 16,
  parameter int VBLANK_LINES = 2,
  parameter int PCLK_DIV     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        pix_ready,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        underrun,
  output logic        busy
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int BW   = $clog2(LINE);

  if (PCLK_DIV < 2 || (PCLK_DIV % 2) != 0 ||
      H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_param_err
    $error("dvp_pixel_tx: illegal parameters");
  end

  logic          tick, pre_tick, frame_end, load, pat;
  dvp_state_e    state_q, state_d;
  logic [BW-1:0] byte_d;
  logic [15:0]   pix_q, pix_d, pat_pix;
  logic [7:0]    data_q, data_d;
  logic          frame_done_q, underrun_q, underrun_d;
  logic          enable_q;

  dvp_tx_timing #(
    .H_ACTIVE     (H_ACTIVE),
    .V_ACTIVE     (V_ACTIVE),
    .H_BLANK      (H_BLANK),
    .VBLANK_LINES (VBLANK_LINES),
    .PCLK_DIV     (PCLK_DIV)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .pclk_o      (pclk),
    .tick_o      (tick),
    .pre_tick_o  (pre_tick),
    .state_o     (state_q),
    .state_d_o   (state_d),
    .byte_d_o    (byte_d),
    .frame_end_o (frame_end)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(byte_d[BW-1:1]) * 32'd8)
                      / 32'(H_ACTIVE));
  assign pat     = pattern_sel;
  assign pat_pix = bar_colour(bar_idx);
`else
  logic unused_byte;
  assign unused_byte = ^byte_d[BW-1:1];
  assign pat         = 1'b0;
  assign pat_pix     = UNDERRUN_PIXEL;
`endif

  // fetch a pixel one clk ahead of each even-byte tick
  assign load = pre_tick && (state_d == ACTIVE) && !byte_d[0];

  assign pix_ready  = load && !pat;
  assign vsync      = (state_q == ACTIVE) || (state_q == HBLANK);
  assign href       = (state_q == ACTIVE);
  assign busy       = (state_q != IDLE);
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // pixel capture, byte mux and sticky underrun
  always_comb begin
    pix_d      = pix_q;
    data_d     = data_q;
    underrun_d = underrun_q;
    if (enable && !enable_q) underrun_d = 1'b0;
    if (load) begin
      if (pat) begin
        pix_d = pat_pix;
      end else if (pix_valid) begin
        pix_d = pix_data;
      end else begin
        pix_d      = UNDERRUN_PIXEL;
        underrun_d = 1'b1;
      end
    end
    if (tick) begin
      if (state_d != ACTIVE) data_d = 8'h00;
      else if (byte_d[0])    data_d = pix_q[7:0];
      else                   data_d = pix_q[15:8];
    end
  end

  // output and pixel registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_q        <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      pix_q        <= pix_d;
      data_q       <= data_d;
      frame_done_q <= tick && frame_end;
      underrun_q   <= underrun_d;
      enable_q     <= enable;
    end
  end

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// tb_dvp_pixel_tx: directed checks of DVP frame timing and pixel bytes.
// Small geometry: 4 px/line, 3 lines, 2 hblank, 2 vblank lines, div 2.
`timescale 1ns/1ps
module tb_dvp_pixel_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0;
`ifdef DVP_TX_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif
  logic        pix_ready, pclk, vsync, href;
  logic [7:0]  data;
  logic        frame_done, underrun, busy;

  int errors = 0;
  int checks = 0;
  int pix_idx = 0;
  int rdy_cnt = 0;
  int drop_slot = -1;
  int fd_cnt = 0;
  int fd_bad = 0;
  logic prev_pclk = 1'b0;
  logic prev_vs = 1'b0;
  logic tick_now = 1'b0;

  dvp_pixel_tx #(
    .H_ACTIVE     (4),
    .V_ACTIVE     (3),
    .H_BLANK      (2),
    .VBLANK_LINES (2),
    .PCLK_DIV     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
`ifdef DVP_TX_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .pix_ready  (pix_ready),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .frame_done (frame_done),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_pix(int n);
    return 16'h1234 + 16'(n) * 16'h4444;
  endfunction

  // {vsync,href,data} for pclk period k after leaving IDLE
  function automatic logic [9:0] frame_exp(int k);
    int j, b;
    logic [15:0] p;
    if (k < 20) return 10'h000;
    j = k - 20;
    b = j % 10;
    if (b >= 8) return 10'h200;
    p = exp_pix((j / 10) * 4 + b / 2);
    return (b % 2 == 1) ? {2'b11, p[7:0]} : {2'b11, p[15:8]};
  endfunction

  // one clk: called and returns at a falling clk edge
  task automatic cyc();
    logic rdy, pv;
    #4;
    rdy = pix_ready;
    pv  = pix_valid;
    @(posedge clk);
    @(negedge clk);
    if (rdy === 1'b1) begin
      rdy_cnt++;
      if (pv) pix_idx++;
    end
    pix_data  = exp_pix(pix_idx);
    pix_valid = (rdy_cnt != drop_slot);
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (vsync !== 1'b0 || prev_vs !== 1'b1) fd_bad++;
    end
    tick_now  = (prev_pclk === 1'b1 && pclk === 1'b0);
    prev_pclk = pclk;
    prev_vs   = vsync;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_now && n < 8);
    if (!tick_now) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no pclk fall in %0d clk", n);
    end
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 4) begin
      next_tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%b want 1", busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    drop_slot = -1;
    repeat (3) cyc();
    pix_idx = 0;
    rdy_cnt = 0;
    fd_cnt = 0;
    fd_bad = 0;
    pix_data = exp_pix(0);
    pix_valid = 1'b1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    logic p;
    do_reset();
    rst = 1'b0;
    cyc();
    got = {pclk, vsync, href, data, frame_done,
           underrun, busy, pix_ready};
    checks++;
    if (got !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000", got);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = pclk;
      cyc();
      checks++;
      if (pclk !== ~p) begin
        errors++;
        $display("FAIL pclk_toggle%0d: got %b want %b", i, pclk, ~p);
      end
    end
    got = {1'b0, vsync, href, data, frame_done,
           underrun, busy, pix_ready};
    checks++;
    if (got !== 14'h0) begin
      errors++;
      $display("FAIL idle_outputs: got %h want 0000", got);
    end
  endtask

  task automatic test_frame();
    logic [9:0] got, exp;
    do_reset();
    enable = 1'b1;
    wait_busy();
    for (int k = 0; k < 50; k++) begin
      got = {vsync, href, data};
      exp = frame_exp(k);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_p%0d: got %h want %h", k, got, exp);
      end
      next_tick();
    end
    checks++;
    if (vsync !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_end: vsync=%b busy=%b want 0 1",
               vsync, busy);
    end
    checks++;
    if (fd_cnt !== 1 || fd_bad !== 0) begin
      errors++;
      $display("FAIL frame_done: pulses=%0d bad=%0d want 1 0",
               fd_cnt, fd_bad);
    end
    checks++;
    if (rdy_cnt !== 12) begin
      errors++;
      $display("FAIL ready_count: got %0d want 12", rdy_cnt);
    end
    enable = 1'b0;
    next_tick();
    checks++;
    if (busy !== 1'b0 || vsync !== 1'b0) begin
      errors++;
      $display("FAIL vblank_abort: busy=%b vsync=%b want 0 0",
               busy, vsync);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] ub [8];
    logic [8:0] got, exp;
    ub = '{8'h12, 8'h34, 8'h00, 8'h00,
           8'h56, 8'h78, 8'h9A, 8'hBC};
    do_reset();
    drop_slot = 1;
    enable = 1'b1;
    wait_busy();
    repeat (20) next_tick();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_early: got %b want 0", underrun);
    end
    for (int b = 0; b < 8; b++) begin
      got = {href, data};
      exp = {1'b1, ub[b]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL underrun_b%0d: got %h want %h", b, got, exp);
      end
      next_tick();
    end
    next_tick();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: got %b want 1", underrun);
    end
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] got, exp;
    int hi;
    do_reset();
    enable = 1'b1;
    wait_busy();
    for (int k = 0; k < 50; k++) begin
      if (k == 32) enable = 1'b0;
      got = {vsync, href, data};
      exp = frame_exp(k);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drop_p%0d: got %h want %h", k, got, exp);
      end
      next_tick();
    end
    checks++;
    if (busy !== 1'b0 || vsync !== 1'b0 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL drop_end: busy=%b vsync=%b fd=%0d want 0 0 1",
               busy, vsync, fd_cnt);
    end
    hi = 0;
    for (int k = 0; k < 24; k++) begin
      next_tick();
      if (vsync !== 1'b0 || busy !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL drop_idle: active periods=%0d want 0", hi);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    do_reset();
    enable = 1'b1;
    wait_busy();
    repeat (22) next_tick();
    rst = 1'b0;
    cyc();
    got = {vsync, href, data, busy};
    checks++;
    if (got !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid: got %h want 000", got);
    end
    cyc();
    cyc();
    checks++;
    if (fd_cnt !== 0) begin
      errors++;
      $display("FAIL rst_no_fd: pulses=%0d want 0", fd_cnt);
    end
    pix_idx = 0;
    rdy_cnt = 0;
    pix_data = exp_pix(0);
    pix_valid = 1'b1;
    rst = 1'b1;
    wait_busy();
    repeat (19) next_tick();
    checks++;
    if (vsync !== 1'b0 || href !== 1'b0) begin
      errors++;
      $display("FAIL rst_vblank: vsync=%b href=%b want 0 0",
               vsync, href);
    end
    next_tick();
    checks++;
    if ({vsync, href, data} !== 10'h312) begin
      errors++;
      $display("FAIL rst_restart0: got %h want 312",
               {vsync, href, data});
    end
    next_tick();
    checks++;
    if ({vsync, href, data} !== 10'h334) begin
      errors++;
      $display("FAIL rst_restart1: got %h want 334",
               {vsync, href, data});
    end
  endtask

`ifdef DVP_TX_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [7:0] pb [8];
    pb = '{8'hFF, 8'hFF, 8'h07, 8'hFF,
           8'hF8, 8'h1F, 8'h00, 8'h1F};
    do_reset();
    pattern_sel = 1'b1;
    enable = 1'b1;
    wait_busy();
    repeat (20) next_tick();
    for (int b = 0; b < 8; b++) begin
      checks++;
      if ({href, data} !== {1'b1, pb[b]}) begin
        errors++;
        $display("FAIL pattern_b%0d: got %h want %h",
                 b, {href, data}, {1'b1, pb[b]});
      end
      next_tick();
    end
    checks++;
    if (rdy_cnt !== 0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL pattern_flags: ready=%0d underrun=%b want 0 0",
               rdy_cnt, underrun);
    end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
`ifdef DVP_TX_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
